grid_renderer: RTL and testbench
================================

# grid_renderer

Frame renderer on the display side of the game state bus. Once per frame, on a start strobe from the control FSM, it raster-scans the 160x120 screen and emits one pixel per cycle to the VGA adapter write port. Each pixel's colour comes from the user ship, enemy ship and bullet grid produced by the logic handler. This block reads the game state; the logic handler writes it.

## Interface
Parameters:
- SCREEN_W, 160, pixels per row
- SCREEN_H, 120, rows per frame
- SHIP_W, 8, ship sprite width in pixels
- SHIP_H, 8, ship sprite height in pixels
- USER_COLOUR, 3'b010, user ship colour
- ENEMY_COLOUR, 3'b100, enemy ship colour
- BULLET_COLOUR, 3'b111, active bullet colour
- BG_COLOUR, 3'b000, background colour

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high reset
- drawEn  in  1  FSM strobe that starts a frame render
- grid  in  19200  bullet bitmap; bit y*160+x set = bullet at (x,y)
- user_x  in  8  user ship top-left x
- user_y  in  7  user ship top-left y
- enemy_x  in  8  enemy ship top-left x
- enemy_y  in  7  enemy ship top-left y
- x  out  8  pixel x to VGA adapter
- y  out  7  pixel y to VGA adapter
- colour  out  3  pixel colour to VGA adapter
- plot  out  1  pixel write enable to VGA adapter
- busy  out  1  high while a frame is in progress
- frame_done  out  1  one-cycle pulse after the last pixel

## Operation
- States:
  - IDLE: no pixels emitted. drawEn=1 latches user_x/y and enemy_x/y into snapshot registers, clears the scan counters, and moves to SCAN.
  - SCAN: one pixel per cycle, row-major. sx runs 0..159 within a row; sy increments when sx wraps from 159 to 0.
  - DONE: lasts one cycle, asserts frame_done, then returns to IDLE.
- SCAN leaves for DONE on the cycle that processes sx=159, sy=119.
- Pixel colour priority, highest first: user sprite, enemy sprite, bullet, background.
  - User sprite hit: snap_ux <= sx <= snap_ux+SHIP_W-1 and snap_uy <= sy <= snap_uy+SHIP_H-1.
  - Enemy sprite hit: same test using the enemy snapshot.
  - Bullet hit: grid[sy*160+sx].
- Sprite bounds are computed 9 bits wide, so x+SHIP_W past 255 does not wrap. Sprite parts beyond column 159 or row 119 are never emitted (clipped).
- Ship positions come from the snapshot registers for the whole frame, so a ship cannot tear mid-frame.
- grid is sampled live. The FSM must not assert gridUpdateEn while busy=1.
- drawEn while busy=1 is ignored. It is neither queued nor allowed to restart the scan.
- busy=1 in SCAN and DONE, 0 in IDLE.
- Reset, at any time including mid-frame:
  - state returns to IDLE
  - x, y, colour, plot, busy, frame_done and the snapshot registers all go to 0
  - the first drawEn after reset deassertion starts a full frame at (0,0)

## Timing
- x, y, colour and plot are registered: one cycle of latency from the scan counter to the outputs.
- Cycle 0 is the drawEn sample edge in IDLE. Then:
  - cycle 1: busy=1; (0,0) is computed
  - cycle 2: first plot=1, with x=0, y=0
  - cycle 19201: last plot=1, with x=159, y=119
  - frame_done=1 for exactly one cycle, coincident with the last pixel output
  - busy falls with frame_done
- A new drawEn is accepted on the cycle after frame_done. The minimum frame period is 19202 cycles.
- plot=1 for exactly 19200 consecutive cycles per frame and is 0 otherwise. x, y and colour are don't-care while plot=0 but are held at their last values.
- x/y wrap, row 0 to row 1: x=159,y=0 is followed by x=0,y=1.

## Test plan
- Empty grid, user (10,100), enemy (70,5), pulse drawEn -> 19200 plots; (10..17, 100..107) = 3'b010; (70..77, 5..12) = 3'b100; all other pixels 3'b000; frame_done one cycle, aligned with (159,119).
- Grid bits set at (0,0), (159,119) and (12,102); user at (10,100) -> (0,0) and (159,119) = 3'b111; (12,102) = 3'b010 (user outranks bullet).
- Clipping: user_x=156, user_y=116 -> only columns 156..159 of rows 116..119 are user colour; x never exceeds 159 and y never exceeds 119.
- Snapshot: change user_x from 10 to 50 at cycle 5000 -> the whole frame draws the ship at x=10; the next frame draws it at x=50.
- drawEn pulsed again at cycle 100 -> ignored; exactly 19200 plots and one frame_done; drawEn the cycle after frame_done starts a new frame at (0,0).
- Reset asserted at cycle 8000 -> plot, busy and frame_done go to 0 immediately; after release, drawEn yields a full frame starting at x=0, y=0.

Source files
------------

// File: rtl/grid_renderer_if.sv
// grid_renderer_if: VGA adapter write port carrying one pixel per cycle
// x/y: pixel coordinate, colour: 3-bit pixel colour, plot: pixel write enable
interface grid_renderer_if;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  modport master (output x, y, colour, plot);
  modport slave (input x, y, colour, plot);
endinterface

// File: rtl/grid_renderer.sv
// grid_renderer: raster-scans the screen once per drawEn and paints ships and bullets to the VGA port
// clk/reset: clock and async active-high reset; drawEn: frame start strobe
// grid: bullet bitmap (bit y*SCREEN_W+x); user_x/y, enemy_x/y: ship top-left corners
// vga: registered pixel write port; busy: frame in progress; frame_done: pulse with the last pixel
module grid_renderer #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int SHIP_W = 8,
  parameter int SHIP_H = 8,
  parameter logic [2:0] USER_COLOUR = 3'b010,
  parameter logic [2:0] ENEMY_COLOUR = 3'b100,
  parameter logic [2:0] BULLET_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         drawEn,
  input  logic [SCREEN_W*SCREEN_H-1:0] grid,
  input  logic [7:0]                   user_x,
  input  logic [6:0]                   user_y,
  input  logic [7:0]                   enemy_x,
  input  logic [6:0]                   enemy_y,
  grid_renderer_if.master              vga,
  output logic                         busy,
  output logic                         frame_done
);
  localparam int IW = $clog2(SCREEN_W * SCREEN_H);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] sx_q, sx_d, ux_q, ux_d, ex_q, ex_d, x_q, x_d;
  logic [6:0] sy_q, sy_d, uy_q, uy_d, ey_q, ey_d, y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d;
  logic       user_hit, enemy_hit, row_end, last;
  logic [IW-1:0] idx;
  // Upper bounds are widened by one bit so a ship near x=255 or y=127 does not wrap to the left/top edge
  assign user_hit = sx_q >= ux_q && 9'(sx_q) <= 9'(ux_q) + 9'(SHIP_W - 1) &&
                    sy_q >= uy_q && 8'(sy_q) <= 8'(uy_q) + 8'(SHIP_H - 1);
  assign enemy_hit = sx_q >= ex_q && 9'(sx_q) <= 9'(ex_q) + 9'(SHIP_W - 1) &&
                     sy_q >= ey_q && 8'(sy_q) <= 8'(ey_q) + 8'(SHIP_H - 1);
  assign idx = IW'(sy_q) * IW'(SCREEN_W) + IW'(sx_q);
  assign row_end = sx_q == 8'(SCREEN_W - 1);
  assign last = row_end && sy_q == 7'(SCREEN_H - 1);
  always_comb begin
    state_d = state_q;
    sx_d = sx_q;
    sy_d = sy_q;
    ux_d = ux_q;
    uy_d = uy_q;
    ex_d = ex_q;
    ey_d = ey_q;
    x_d = x_q;
    y_d = y_q;
    colour_d = colour_q;
    plot_d = 1'b0;
    case (state_q)
      IDLE: if (drawEn) begin
        state_d = SCAN;
        sx_d = '0;
        sy_d = '0;
        ux_d = user_x;
        uy_d = user_y;
        ex_d = enemy_x;
        ey_d = enemy_y;
      end
      SCAN: begin
        plot_d = 1'b1;
        x_d = sx_q;
        y_d = sy_q;
        colour_d = user_hit ? USER_COLOUR : enemy_hit ? ENEMY_COLOUR : grid[idx] ? BULLET_COLOUR : BG_COLOUR;
        sx_d = row_end ? '0 : sx_q + 8'd1;
        sy_d = row_end ? sy_q + 7'd1 : sy_q;
        state_d = last ? DONE : SCAN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sx_q <= '0;
      sy_q <= '0;
      ux_q <= '0;
      uy_q <= '0;
      ex_q <= '0;
      ey_q <= '0;
      x_q <= '0;
      y_q <= '0;
      colour_q <= '0;
      plot_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sx_q <= sx_d;
      sy_q <= sy_d;
      ux_q <= ux_d;
      uy_q <= uy_d;
      ex_q <= ex_d;
      ey_q <= ey_d;
      x_q <= x_d;
      y_q <= y_d;
      colour_q <= colour_d;
      plot_q <= plot_d;
    end
  end
  assign busy = state_q != IDLE;
  assign frame_done = state_q == DONE;
  assign vga.x = x_q;
  assign vga.y = y_q;
  assign vga.colour = colour_q;
  assign vga.plot = plot_q;
endmodule

// File: tb/tb_grid_renderer.sv
// tb_grid_renderer: randomized frame checks of grid_renderer against a screen-level colour model
module tb_grid_renderer;
  localparam int W = 160, H = 120, N = W * H;
  logic clk = 1'b0, reset = 1'b1, drawEn = 1'b0;
  logic [N-1:0] grid_v = '0;
  logic [7:0] user_x = '0, enemy_x = '0;
  logic [6:0] user_y = '0, enemy_y = '0;
  logic busy, frame_done;
  grid_renderer_if vga ();
  grid_renderer dut (
    .clk(clk), .reset(reset), .drawEn(drawEn), .grid(grid_v),
    .user_x(user_x), .user_y(user_y), .enemy_x(enemy_x), .enemy_y(enemy_y),
    .vga(vga), .busy(busy), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;
  int n_cmp = 0, n_bad = 0;
  int plot_cnt, fd_cnt, fd_bad, seq_err, range_err, busy_cnt, first_cyc, last_cyc, nxt;
  int s_prev;
  logic [3:0] pix [N];
  task automatic clear_mon();
    plot_cnt = 0; fd_cnt = 0; fd_bad = 0; seq_err = 0; range_err = 0;
    busy_cnt = 0; first_cyc = -1; last_cyc = -1; nxt = 0;
    for (int i = 0; i < N; i++) pix[i] = 4'hf;
  endtask
  always @(negedge clk) begin
    if (vga.plot) begin
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      plot_cnt++;
      if (int'(vga.x) >= W || int'(vga.y) >= H) range_err++;
      else begin
        if (int'(vga.y) * W + int'(vga.x) != nxt) seq_err++;
        pix[int'(vga.y) * W + int'(vga.x)] = {1'b0, vga.colour};
      end
      nxt++;
    end
    if (frame_done) begin
      fd_cnt++;
      if (!(vga.plot && vga.x == 8'd159 && vga.y == 7'd119)) fd_bad++;
    end
    if (busy) busy_cnt++;
  end
  function automatic logic [2:0] model(int px, int py, int ux, int uy, int ex, int ey);
    if (px >= ux && px < ux + 8 && py >= uy && py < uy + 8) return 3'b010;
    if (px >= ex && px < ex + 8 && py >= ey && py < ey + 8) return 3'b100;
    return grid_v[py * W + px] ? 3'b111 : 3'b000;
  endfunction
  function automatic int pixel_errs(int ux, int uy, int ex, int ey);
    int e = 0;
    for (int py = 0; py < H; py++)
      for (int px = 0; px < W; px++)
        if (pix[py * W + px] !== {1'b0, model(px, py, ux, uy, ex, ey)}) e++;
    return e;
  endfunction
  task automatic rand_grid();
    for (int i = 0; i < N; i++) grid_v[i] = ($urandom_range(7) == 0);
  endtask
  task automatic wait_cyc(int t);
    while (cyc < t) begin @(posedge clk); #1; end
  endtask
  task automatic start_frame(output int s);
    clear_mon();
    @(posedge clk); #1 drawEn = 1'b1;
    @(posedge clk); #1 s = cyc; drawEn = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (vga.plot !== 1'b0) begin n_bad++; $display("FAIL rst_plot: got %b want 0", vga.plot); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", frame_done); end
    n_cmp++; if (vga.x !== 8'd0 || vga.y !== 7'd0) begin n_bad++; $display("FAIL rst_xy: got %0d,%0d want 0,0", vga.x, vga.y); end
    n_cmp++; if (vga.colour !== 3'd0) begin n_bad++; $display("FAIL rst_colour: got %0d want 0", vga.colour); end
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0 || vga.plot !== 1'b0) begin n_bad++; $display("FAIL idle_quiet: got busy=%b plot=%b want 0,0", busy, vga.plot); end
  endtask
  task automatic test_priority_snapshot();
    int s, e;
    grid_v = '0;
    grid_v[0] = 1'b1;
    grid_v[N - 1] = 1'b1;
    grid_v[102 * W + 12] = 1'b1;
    user_x = 8'd10; user_y = 7'd100; enemy_x = 8'd70; enemy_y = 7'd5;
    start_frame(s);
    wait_cyc(s + 100);
    drawEn = 1'b1;
    @(posedge clk); #1 drawEn = 1'b0;
    wait_cyc(s + 5000);
    user_x = 8'd50;
    wait_cyc(s + 19200);
    @(negedge clk); #1;
    e = pixel_errs(10, 100, 70, 5);
    n_cmp++; if (plot_cnt !== 19200) begin n_bad++; $display("FAIL f1_plots: got %0d want 19200", plot_cnt); end
    n_cmp++; if (first_cyc !== s + 1) begin n_bad++; $display("FAIL f1_first: got %0d want %0d", first_cyc - s, 1); end
    n_cmp++; if (last_cyc !== s + 19200) begin n_bad++; $display("FAIL f1_last: got %0d want %0d", last_cyc - s, 19200); end
    n_cmp++; if (fd_cnt !== 1 || fd_bad !== 0) begin n_bad++; $display("FAIL f1_done: got count=%0d misaligned=%0d want 1,0", fd_cnt, fd_bad); end
    n_cmp++; if (seq_err !== 0 || range_err !== 0) begin n_bad++; $display("FAIL f1_order: got seq=%0d range=%0d want 0,0", seq_err, range_err); end
    n_cmp++; if (busy_cnt !== 19201) begin n_bad++; $display("FAIL f1_busy: got %0d want 19201", busy_cnt); end
    n_cmp++; if (e !== 0) begin n_bad++; $display("FAIL f1_pixels: got %0d wrong want 0", e); end
    n_cmp++; if (pix[0] !== 4'd7 || pix[N - 1] !== 4'd7) begin n_bad++; $display("FAIL f1_bullet: got %0d,%0d want 7,7", pix[0], pix[N - 1]); end
    n_cmp++; if (pix[102 * W + 12] !== 4'd2) begin n_bad++; $display("FAIL f1_user_over_bullet: got %0d want 2", pix[102 * W + 12]); end
    n_cmp++; if (pix[5 * W + 70] !== 4'd4 || pix[12 * W + 77] !== 4'd4) begin n_bad++; $display("FAIL f1_enemy: got %0d,%0d want 4,4", pix[5 * W + 70], pix[12 * W + 77]); end
    n_cmp++; if (pix[100 * W + 50] !== 4'd0 || pix[107 * W + 17] !== 4'd2) begin n_bad++; $display("FAIL f1_snapshot: got %0d,%0d want 0,2", pix[100 * W + 50], pix[107 * W + 17]); end
    s_prev = s;
  endtask
  task automatic test_back_to_back();
    int s, e, ex, ey;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0 || frame_done !== 1'b0 || vga.plot !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: got busy=%b done=%b plot=%b want 0,0,0", busy, frame_done, vga.plot); end
    clear_mon();
    rand_grid();
    ex = $urandom_range(200); ey = $urandom_range(127);
    enemy_x = 8'(ex); enemy_y = 7'(ey);
    drawEn = 1'b1;
    @(posedge clk); #1 s = cyc; drawEn = 1'b0;
    wait_cyc(s + 19200);
    @(negedge clk); #1;
    e = pixel_errs(50, 100, ex, ey);
    n_cmp++; if (first_cyc !== s_prev + 19203) begin n_bad++; $display("FAIL b2b_first: got %0d want %0d", first_cyc - s_prev, 19203); end
    n_cmp++; if (plot_cnt !== 19200 || fd_cnt !== 1 || fd_bad !== 0) begin n_bad++; $display("FAIL b2b_frame: got plots=%0d done=%0d misaligned=%0d want 19200,1,0", plot_cnt, fd_cnt, fd_bad); end
    n_cmp++; if (seq_err !== 0) begin n_bad++; $display("FAIL b2b_order: got %0d want 0", seq_err); end
    n_cmp++; if (e !== 0) begin n_bad++; $display("FAIL b2b_pixels: got %0d wrong want 0 (enemy %0d,%0d)", e, ex, ey); end
    n_cmp++; if (pix[100 * W + 50] !== 4'd2) begin n_bad++; $display("FAIL b2b_new_user: got %0d want 2", pix[100 * W + 50]); end
  endtask
  task automatic test_reset_midframe();
    int s;
    rand_grid();
    user_x = 8'($urandom_range(159)); user_y = 7'($urandom_range(119));
    start_frame(s);
    wait_cyc(s + 8000);
    reset = 1'b1;
    #1;
    n_cmp++; if (vga.plot !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ctrl: got plot=%b busy=%b done=%b want 0,0,0", vga.plot, busy, frame_done); end
    n_cmp++; if (vga.x !== 8'd0 || vga.y !== 7'd0 || vga.colour !== 3'd0) begin n_bad++; $display("FAIL mid_rst_pix: got %0d,%0d,%0d want 0,0,0", vga.x, vga.y, vga.colour); end
    n_cmp++; if (plot_cnt !== 7999) begin n_bad++; $display("FAIL mid_rst_plots: got %0d want 7999", plot_cnt); end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0 || vga.plot !== 1'b0) begin n_bad++; $display("FAIL mid_rst_idle: got busy=%b plot=%b want 0,0", busy, vga.plot); end
  endtask
  task automatic test_clip_random();
    int s, e, ex, ey;
    rand_grid();
    ex = $urandom_range(150, 255); ey = $urandom_range(110, 127);
    user_x = 8'd156; user_y = 7'd116; enemy_x = 8'(ex); enemy_y = 7'(ey);
    start_frame(s);
    wait_cyc(s + 19200);
    @(negedge clk); #1;
    e = pixel_errs(156, 116, ex, ey);
    n_cmp++; if (first_cyc !== s + 1 || last_cyc !== s + 19200) begin n_bad++; $display("FAIL clip_window: got %0d..%0d want 1..19200", first_cyc - s, last_cyc - s); end
    n_cmp++; if (plot_cnt !== 19200 || fd_cnt !== 1 || fd_bad !== 0) begin n_bad++; $display("FAIL clip_frame: got plots=%0d done=%0d misaligned=%0d want 19200,1,0", plot_cnt, fd_cnt, fd_bad); end
    n_cmp++; if (range_err !== 0 || seq_err !== 0) begin n_bad++; $display("FAIL clip_range: got range=%0d seq=%0d want 0,0", range_err, seq_err); end
    n_cmp++; if (e !== 0) begin n_bad++; $display("FAIL clip_pixels: got %0d wrong want 0 (enemy %0d,%0d)", e, ex, ey); end
    n_cmp++; if (pix[116 * W + 156] !== 4'd2 || pix[N - 1] !== 4'd2) begin n_bad++; $display("FAIL clip_corner: got %0d,%0d want 2,2", pix[116 * W + 156], pix[N - 1]); end
  endtask
  initial begin
    test_reset();
    test_priority_snapshot();
    test_back_to_back();
    test_reset_midframe();
    test_clip_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #1500000;
    $display("FAIL watchdog: got no end of run by 1500000 want earlier finish");
    $fatal(1);
  end
endmodule
